// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: shared state encoding, default widths and phase-counter width
// for the register-file bus master and its phase timer.
package reg_bus_pkg;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 3;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_STRB,
        WR_HOLD,
        RD_SETUP,
        RD_STRB,
        RD_TURN
    } state_t;
endpackage

// File: rtl/reg_bus_phase_timer.sv
// reg_bus_phase_timer: loadable 3-bit down-counter timing the SETUP and STRB phases.
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   load_i     load load_val_i (phase length minus one) on this edge
//   load_val_i cycles remaining in the phase, minus one
//   done_o     high during the last cycle of the phase
module reg_bus_phase_timer
    import reg_bus_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign done_o = cnt_q == '0;
endmodule

// File: rtl/reg_bus_master.sv
// reg_bus_master: sequences single writes and single/burst reads from a valid/ready
// request port onto the asynchronous register-file bus, with a turnaround cycle after
// every read strobe so DATA is never driven by both sides.
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i / req_ready_o    request handshake (ready only in IDLE, not in reset)
//   req_write_i, req_addr_i      1 = write / 0 = read, start address
//   req_wdata_i, req_len_i       write data, read beats minus one
//   rsp_valid_o                  one-cycle pulse per read beat
//   rsp_data_o, rsp_addr_o       captured beat data and its address
//   busy_o                       high whenever a transaction is in progress
//   addr_o, data_io              register-file address and bidirectional data
//   oe_o, ws_o, cs_o             output enable, write strobe (active high), chip select (active low)
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SETUP_CYC = 1,
    parameter int STRB_CYC  = 1,
    parameter int LEN_W     = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [LEN_W-1:0]  req_len_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [ADDR_W-1:0] rsp_addr_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] addr_o,
    inout  wire  [DATA_W-1:0] data_io,
    output logic              oe_o,
    output logic              ws_o,
    output logic              cs_o
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rsp_data_q, rsp_data_d;
    logic [LEN_W-1:0]  left_q, left_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              cs_q, cs_d, oe_q, oe_d, ws_q, ws_d, drv_q, drv_d;
    logic              done, load;
    logic [CNT_W-1:0]  load_val;

    assign req_ready_o = (state_q == IDLE) && !rst_i;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        left_d      = left_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
        case (state_q)
            IDLE: if (req_valid_i && req_ready_o) begin
                state_d = req_write_i ? WR_SETUP : RD_SETUP;
                addr_d  = req_addr_i;
                wdata_d = req_wdata_i;
                left_d  = req_write_i ? '0 : req_len_i;
            end
            WR_SETUP: state_d = done ? WR_STRB : WR_SETUP;
            WR_STRB:  state_d = done ? WR_HOLD : WR_STRB;
            WR_HOLD:  state_d = IDLE;
            RD_SETUP: state_d = done ? RD_STRB : RD_SETUP;
            RD_STRB: if (done) begin
                state_d     = RD_TURN;
                rsp_valid_d = 1'b1;
                rsp_data_d  = data_io;
                rsp_addr_d  = addr_q;
            end
            RD_TURN: if (left_q == '0) state_d = IDLE;
            else begin
                state_d = RD_SETUP;
                addr_d  = addr_q + 1'b1;
                left_d  = left_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Bus controls are registered from the next state so the strobes come straight off flops.
        cs_d  = state_d == IDLE;
        oe_d  = state_d == RD_STRB;
        ws_d  = state_d == WR_STRB;
        drv_d = state_d inside {WR_SETUP, WR_STRB, WR_HOLD};
    end

    // The timer is reloaded on entry to every timed phase, including each new burst beat.
    assign load     = (state_d != state_q) && (state_d inside {WR_SETUP, WR_STRB, RD_SETUP, RD_STRB});
    assign load_val = (state_d inside {WR_SETUP, RD_SETUP}) ? CNT_W'(SETUP_CYC - 1) : CNT_W'(STRB_CYC - 1);

    reg_bus_phase_timer u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (load),
        .load_val_i (load_val),
        .done_o     (done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            left_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            cs_q        <= 1'b1;
            oe_q        <= 1'b0;
            ws_q        <= 1'b0;
            drv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            left_q      <= left_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
            cs_q        <= cs_d;
            oe_q        <= oe_d;
            ws_q        <= ws_d;
            drv_q       <= drv_d;
        end
    end

    assign data_io     = drv_q ? wdata_q : 'z;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_addr_o  = rsp_addr_q;
    assign busy_o      = state_q != IDLE;
    assign addr_o      = addr_q;
    assign oe_o        = oe_q;
    assign ws_o        = ws_q;
    assign cs_o        = cs_q;
endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master: drives reg_bus_master against an attached register-file model and
// checks responses, latencies and bus timing against a memory-array reference model.
module tb_reg_bus_master;
    logic       clk = 1'b0, rst = 1'b1;
    logic       req_valid = 1'b0, req_write = 1'b0;
    logic [4:0] req_addr = '0, req_len = '0;
    logic [7:0] req_wdata = '0;
    wire        req_ready, rsp_valid, busy, oe, ws, cs;
    wire  [4:0] rsp_addr, addr;
    wire  [7:0] rsp_data;
    wire  [7:0] data_bus;

    reg_bus_master dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_len_i   (req_len),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_addr_o  (rsp_addr),
        .busy_o      (busy),
        .addr_o      (addr),
        .data_io     (data_bus),
        .oe_o        (oe),
        .ws_o        (ws),
        .cs_o        (cs)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [32];
    logic [7:0] ref_mem [32];
    assign data_bus = (!cs && oe) ? mem[addr] : 'z;
    always @(negedge ws) if (!cs) mem[addr] = data_bus;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rq_d [$];
    logic [4:0] rq_a [$];
    int         rq_c [$];
    always @(negedge clk) if (rsp_valid) begin
        rq_d.push_back(rsp_data);
        rq_a.push_back(rsp_addr);
        rq_c.push_back(cyc);
    end

    function automatic bit released(input logic [7:0] v);
        return $isunknown(v) || v == 8'h00;
    endfunction

    int mon_bad = 0, ws_pulses = 0, acc_count = 0, ws_run = 0;
    logic prev_ws = 1'b0, prev_oe = 1'b0, prev_cs = 1'b1;
    logic [7:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (oe && ws) mon_bad++;
            if (oe && cs) mon_bad++;
            if (oe && data_bus !== mem[addr]) mon_bad++;
            if ((!busy || (prev_oe && !oe)) && !released(data_bus)) mon_bad++;
            if (cs != !busy) mon_bad++;
            if (req_ready && busy) mon_bad++;
            if (ws && !prev_ws) begin
                ws_pulses++;
                if (cs || prev_cs || data_bus !== prev_data) mon_bad++;
            end
            if (!ws && prev_ws && (ws_run != 1 || cs || data_bus !== prev_data)) mon_bad++;
            if (req_valid && req_ready) acc_count++;
        end
        ws_run    = ws ? ws_run + 1 : 0;
        prev_ws   = ws;
        prev_oe   = oe;
        prev_cs   = cs;
        prev_data = data_bus;
    end

    int total = 0, bad = 0;
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input bit wr, input logic [4:0] a, input logic [7:0] d, input logic [4:0] len, output int acc);
        @(negedge clk);
        req_write = wr; req_addr = a; req_wdata = d; req_len = len; req_valid = 1'b1;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        if (!req_ready) check("accept_timeout", 0, 1);
        acc = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_addr = ~a; req_wdata = ~d; req_len = ~len;
    endtask

    task automatic run(input bit wr, input logic [4:0] a, input logic [7:0] d, input logic [4:0] len,
                       input int exp_busy, output int beats, output logic [7:0] first);
        int acc, b, ws0, base;
        logic [4:0] ea;
        base = rq_d.size();
        ws0 = ws_pulses;
        issue(wr, a, d, len, acc);
        b = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            b++;
        end
        check("busy_cycles", b, exp_busy);
        check("ws_pulses", ws_pulses - ws0, int'(wr));
        if (wr) begin
            ref_mem[a] = d;
            check("rf_write", int'(mem[a]), int'(d));
        end
        beats = rq_d.size() - base;
        first = beats > 0 ? rq_d[base] : 8'h00;
        check("beats", beats, wr ? 0 : int'(len) + 1);
        for (int i = 0; i < beats; i++) begin
            ea = a + 5'(i);
            check("rsp_addr", int'(rq_a[base+i]), int'(ea));
            check("rsp_data", int'(rq_d[base+i]), int'(ref_mem[ea]));
            check("rsp_latency", rq_c[base+i] - acc, 3 + 3 * i);
        end
    endtask

    typedef struct {
        bit         wr;
        logic [4:0] a;
        logic [7:0] d;
        logic [4:0] len;
        int         exp_busy;
        int         exp_beats;
        logic [7:0] exp_first;
    } vec_t;
    vec_t tbl [$];

    initial begin
        int beats, acc, prev_acc, ws0, acc0;
        logic [7:0] first, d;
        logic [4:0] a, len;
        bit wr;
        tbl.push_back('{1'b1, 5'd0, 8'd31, 5'd0, 3, 0, 8'd0});
        tbl.push_back('{1'b0, 5'd0, 8'd0, 5'd0, 3, 1, 8'd31});
        for (int i = 0; i < 32; i++) tbl.push_back('{1'b1, 5'(i), 8'(31 + i), 5'(i), 3, 0, 8'd0});
        tbl.push_back('{1'b0, 5'd4, 8'd0, 5'd6, 21, 7, 8'd35});
        tbl.push_back('{1'b0, 5'd30, 8'd0, 5'd3, 12, 4, 8'd61});
        tbl.push_back('{1'b0, 5'd31, 8'd0, 5'd31, 96, 32, 8'd62});

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cs", cs, 1);
        check("rst_oe", oe, 0);
        check("rst_ws", ws, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", int'(rsp_data), 0);
        check("rst_rsp_addr", int'(rsp_addr), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_data_z", int'(released(data_bus)), 1);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);

        foreach (tbl[i]) begin
            run(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].len, tbl[i].exp_busy, beats, first);
            check("tbl_beats", beats, tbl[i].exp_beats);
            if (!tbl[i].wr) check("tbl_first", int'(first), int'(tbl[i].exp_first));
        end

        ws0 = ws_pulses;
        issue(1'b1, 5'd5, 8'hAA, 5'd0, acc);
        @(negedge clk);
        check("mid_wr_busy", busy, 1);
        check("mid_wr_ws", ws, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cs", cs, 1);
        check("mid_rst_ws", ws, 0);
        check("mid_rst_oe", oe, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_data_z", int'(released(data_bus)), 1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_no_write", ws_pulses - ws0, 0);
        run(1'b0, 5'd5, 8'd0, 5'd0, 3, beats, first);
        check("mid_rst_read", int'(first), 36);

        ws0 = ws_pulses;
        acc0 = acc_count;
        prev_acc = 0;
        @(negedge clk);
        req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_write = 1'b1; req_addr = 5'(8 + k); req_wdata = 8'(8'hC0 + k); req_len = '0;
            for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
            check("b2b_ready", req_ready, 1);
            check("b2b_idle_cs", cs, 1);
            if (k > 0) check("b2b_spacing", cyc - prev_acc, 4);
            prev_acc = cyc;
            ref_mem[8+k] = 8'(8'hC0 + k);
            @(posedge clk);
            if (k == 3) #1 req_valid = 1'b0;
            @(negedge clk);
            check("b2b_not_ready_busy", req_ready, 0);
        end
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        @(negedge clk);
        check("b2b_accepts", acc_count - acc0, 4);
        check("b2b_ws_pulses", ws_pulses - ws0, 4);
        for (int k = 0; k < 4; k++) check("b2b_mem", int'(mem[8+k]), int'(ref_mem[8+k]));

        for (int t = 0; t < 60; t++) begin
            wr  = 1'($urandom_range(0, 1));
            a   = 5'($urandom_range(0, 31));
            d   = 8'($urandom_range(1, 255));
            len = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            run(wr, a, d, len, wr ? 3 : 3 * (int'(len) + 1), beats, first);
        end

        check("bus_monitor", mon_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
